// File: rtl/k_counter_filter.sv
// DPLL "K counter" loop filter: independent modulo-K up/down counters driven by the phase
// detector, emitting carry/borrow pulses, plus a windowed event-rate lock indicator.
module k_counter_filter #(
   parameter int unsigned KMAX_LOG    = 8,
   parameter int unsigned KMIN_LOG    = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned WIN_LEN     = 256,
   parameter int unsigned LOCK_THR    = 2,
   parameter int unsigned EVW         = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           en,
   input  logic           dnUp,
   input  logic [3:0]     kSel,
   output logic           carry,
   output logic           borrow,
   output logic           locked,
   output logic [EVW-1:0] evtCount
);

   localparam int unsigned WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam logic [3:0] KMinL = 4'(KMIN_LOG);
   localparam logic [3:0] KMaxL = 4'(KMAX_LOG);
   localparam logic [KMAX_LOG-1:0] AllOnes = '1;
   localparam logic [WW-1:0] WinLast = WW'(WIN_LEN - 1);
   localparam logic [EVW-1:0] LockThrL = EVW'(LOCK_THR);

   logic dnS;

   if (SYNC_STAGES == 0) begin : gNoSync
      assign dnS = dnUp;
   end else begin : gSync
      logic [SYNC_STAGES-1:0] syncQ;
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            syncQ <= '0;
         end else begin
            syncQ[0] <= dnUp;
            for (int i = 1; i < SYNC_STAGES; i++) syncQ[i] <= syncQ[i-1];
         end
      end
      assign dnS = syncQ[SYNC_STAGES-1];
   end

   logic [3:0]          kReg, kEff;
   logic                kChange;
   logic [KMAX_LOG-1:0] termVal;
   logic [KMAX_LOG-1:0] upCntQ, upCntD, dnCntQ, dnCntD;
   logic                carryQ, carryD, borrowQ, borrowD;
   logic [WW-1:0]       winQ, winD;
   logic [EVW-1:0]      accQ, accD, accInc, evtQ, evtD;
   logic                lockedQ, lockedD;

   always_comb begin
      kEff = kSel;
      if (kSel < KMinL)      kEff = KMinL;
      else if (kSel > KMaxL) kEff = KMaxL;
   end

   assign kChange = (kEff != kReg);
   // K-1 as a right-aligned mask; kReg never exceeds KMAX_LOG.
   assign termVal = AllOnes >> (KMaxL - kReg);

   always_comb begin
      upCntD  = upCntQ;
      dnCntD  = dnCntQ;
      carryD  = 1'b0;
      borrowD = 1'b0;
      if (kChange) begin
         upCntD = '0;
         dnCntD = '0;
      end else if (en) begin
         if (!dnS) begin
            if (upCntQ == termVal) begin
               upCntD = '0;
               carryD = 1'b1;
            end else begin
               upCntD = upCntQ + 1'b1;
            end
         end else begin
            if (dnCntQ == termVal) begin
               dnCntD  = '0;
               borrowD = 1'b1;
            end else begin
               dnCntD = dnCntQ + 1'b1;
            end
         end
      end
   end

   // Saturating event accumulate, including the event produced on this edge.
   assign accInc = (accQ == '1) ? accQ : accQ + EVW'(carryD | borrowD);

   always_comb begin
      winD    = winQ;
      accD    = accQ;
      evtD    = evtQ;
      lockedD = lockedQ;
      if (en) begin
         if (winQ == WinLast) begin
            evtD    = accInc;
            lockedD = (accInc <= LockThrL);
            accD    = '0;
            winD    = '0;
         end else begin
            accD = accInc;
            winD = winQ + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         kReg    <= KMinL;
         upCntQ  <= '0;
         dnCntQ  <= '0;
         carryQ  <= 1'b0;
         borrowQ <= 1'b0;
         winQ    <= '0;
         accQ    <= '0;
         evtQ    <= '0;
         lockedQ <= 1'b0;
      end else begin
         kReg    <= kEff;
         upCntQ  <= upCntD;
         dnCntQ  <= dnCntD;
         carryQ  <= carryD;
         borrowQ <= borrowD;
         winQ    <= winD;
         accQ    <= accD;
         evtQ    <= evtD;
         lockedQ <= lockedD;
      end
   end

   assign carry    = carryQ;
   assign borrow   = borrowQ;
   assign locked   = lockedQ;
   assign evtCount = evtQ;

endmodule

// File: doc/k_counter_filter.md
Name: k_counter_filter

Overview:
- Digital loop filter ("K counter") of the DPLL, directly downstream of the flip-flop phase detector.
- Consumes the detector's 1-bit lead/lag output `dnUp` and produces single-cycle `carry` (advance) and `borrow` (retard) pulses for the increment/decrement DCO stage.
- Implements independent modulo-K up and down counters with runtime-selectable K.
- Includes a windowed event-rate lock indicator.

Parameters:
- KMAX_LOG, 8: log2 of the largest K; sets the counter width.
- KMIN_LOG, 2: log2 of the smallest K.
- SYNC_STAGES, 2: number of synchronizer flops on `dnUp`; 0 means direct use.
- WIN_LEN, 256: lock window length in enabled clk cycles.
- LOCK_THR, 2: `locked` asserts when window events ≤ LOCK_THR.
- EVW, 8: width of the event counter.

Ports:
- clk  in  1  K clock (M × centre frequency).
- reset  in  1  asynchronous, active-low.
- en  in  1  count enable.
- dnUp  in  1  phase-detector output: 1 = count down, 0 = count up.
- kSel  in  4  requested log2(K).
- carry  out  1  one-cycle advance pulse.
- borrow  out  1  one-cycle retard pulse.
- locked  out  1  lock indicator, updated once per window.
- evtCount  out  EVW  carry+borrow count of the last completed window.

Behaviour:
- Reset: clk is the clock; reset is asynchronous and active-low.
  - While reset=0, every flop clears: sync chain, upCnt, dnCnt, kReg, window counter, accumulator.
  - All outputs are 0, including `locked` and `evtCount`.
  - Reset asserted mid-count clears immediately; there is no partial pulse on release.
- Sync:
  - `dnS` is `dnUp` delayed by SYNC_STAGES clk edges.
  - The chain shifts every edge, regardless of `en`.
- K select:
  - `kEff = clamp(kSel, KMIN_LOG, KMAX_LOG)`, registered into kReg every edge; K = 2^kReg.
  - At reset kReg = KMIN_LOG.
  - If `kEff != kReg` on an edge: kReg updates, upCnt and dnCnt clear to 0, and carry/borrow are 0 for the next cycle. Counting resumes the following edge.
- Counting, on each edge with en=1 and no K change:
  - If dnS=0:
    - If upCnt == K-1: upCnt ← 0 and carry ← 1.
    - Otherwise upCnt ← upCnt+1.
    - dnCnt holds.
  - If dnS=1: the same rule applies to dnCnt and borrow; upCnt holds.
- Pulse rules:
  - `carry` and `borrow` are registered, high for exactly one cycle per wrap.
  - They are never both high: only one counter moves per edge.
  - With dnS constant, the pulse period is exactly K edges.
  - The two counters are independent and are not netted (74297 semantics).
- en=0:
  - Counters, window counter and accumulator hold.
  - carry and borrow ← 0.
  - Sync chain and kReg continue to update.
- Lock window, over enabled cycles only:
  - winCnt runs 0..WIN_LEN-1.
  - `acc` increments, saturating at 2^EVW-1, on every edge that sets carry or borrow.
  - On the edge where winCnt == WIN_LEN-1:
    - total = acc plus this edge's event; evtCount ← total.
    - locked ← (total ≤ LOCK_THR).
    - acc ← 0, winCnt ← 0.
  - `locked` and `evtCount` change only at window boundaries or reset.
  - A K change does not reset the window.

Test Plan:
- Reset: hold reset=0, toggle dnUp/en/kSel → carry=borrow=locked=0 and evtCount=0 throughout. Release → no pulse until K counts have elapsed.
- Up count: defaults, kSel=2 (K=4), dnUp=0, en=1 from cycle 0 → first carry after edge 4, then every 4 edges; borrow stays 0.
- Down count: kSel=3, dnUp=1 → after the 2-cycle sync latency, borrow every 8 edges; carry stays 0. Drop en for 5 cycles mid-count → pulse train shifts by exactly 5 cycles.
- Alternating: kSel=2, dnUp toggling every cycle → carry and borrow each every 8 edges, interleaved, never coincident.
- K change and clamp: kSel=15 → K=256 (carry every 256 edges). kSel=0 → K=4. Change kSel 2→3 with upCnt=2 → counters clear, next carry 8 edges after the change cycle.
- Lock: WIN_LEN=256, K=4, dnUp=0 → after 256 enabled cycles, evtCount=64 and locked=0. Then kSel=8 with dnUp alternating → next window evtCount=0 and locked=1.
